instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage sitting directly downstream of `program_counter`: it samples the current 19-bit PC, performs a req/ack read from instruction memory, and holds the fetched word in an instruction register for the decoder. It owns the PC advance: it pulses `pc_enable` exactly once per instruction handed to the decoder. The decoder drives `pc_sel` and `target_addr` to `program_counter` in that same cycle. It also detects memory that never acknowledges a read.

## Interface
- `ADDR_W`, default 19: PC / memory address width.
- `DATA_W`, default 19: instruction width.
- `ACK_TIMEOUT`, default 15: maximum number of REQ cycles without `mem_ack` before a fetch error; legal range 1..255.

- `clk`  input  1: single clock, rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `pc`  input  ADDR_W: current PC from `program_counter`.
- `halt`  input  1: when high, no new fetch is started.
- `pc_enable`  output  1: one-cycle PC advance pulse to `program_counter`.
- `mem_req`  output  1: read request to instruction memory.
- `mem_addr`  output  ADDR_W: read address, stable while `mem_req` is high.
- `mem_ack`  input  1: read data valid this cycle.
- `mem_rdata`  input  DATA_W: read data.
- `ir_valid`  output  1: `ir` holds an instruction for the decoder.
- `ir`  output  DATA_W: instruction register.
- `ir_pc`  output  ADDR_W: address `ir` was fetched from.
- `dec_ready`  input  1: decoder accepts `ir` this cycle.
- `fetch_err`  output  1: sticky memory timeout flag.

## Operation
- FSM states: IDLE, REQ, HOLD, ERR.
- IDLE
  - If `halt` is low, go to REQ and register `mem_addr <= pc`.
  - Otherwise stay in IDLE.
- REQ
  - `mem_req` is 1.
  - On `mem_ack`: `ir <= mem_rdata`, `ir_pc <= mem_addr`, go to HOLD.
  - Otherwise increment `wait_cnt`, an 8-bit counter cleared on entry to REQ.
  - If `mem_ack` is still absent in the REQ cycle where `wait_cnt == ACK_TIMEOUT-1`, go to ERR and set `fetch_err`.
- HOLD
  - `ir_valid` is 1.
  - `pc_enable = (state==HOLD) && dec_ready`. This is combinational, so `program_counter` updates on the same edge as the handoff.
  - On handoff, go to IDLE.
  - `ir` and `ir_pc` stay unchanged until the next ack.
- ERR
  - Terminal state: `mem_req=0`, `ir_valid=0`, `pc_enable=0`, `fetch_err=1`.
  - Only `rst` leaves ERR.
- `halt` does not abort an in-flight request or a held instruction. It only blocks the IDLE->REQ transition.
- `mem_ack` is ignored outside REQ; `ir` is not written.
- `dec_ready` is ignored outside HOLD; `pc_enable` stays 0.
- `mem_addr` is captured in IDLE, one cycle after the PC update. It therefore always reflects the post-branch or post-increment PC.
- An ack arriving in the same cycle as the timeout condition takes priority: data is captured and the FSM goes to HOLD, not ERR.

## Timing
- Reset (asynchronous, immediate): state=IDLE; `mem_req`, `pc_enable`, `ir_valid`, `fetch_err` all 0; `mem_addr`, `ir`, `ir_pc` all 0; `wait_cnt`=0.
- Reset asserted mid-REQ or mid-HOLD drops `mem_req` / `ir_valid` immediately. The pending memory response is discarded.
- `mem_req`, `mem_addr`, `ir_valid`, `ir`, `ir_pc`, `fetch_err` are state-derived or registered, with no combinational path from inputs.
- `pc_enable` is the only combinational output.
- Minimum per-instruction period is 3 cycles: IDLE, REQ with same-cycle ack, HOLD with `dec_ready`=1.
- Each extra memory wait cycle adds 1. Each cycle `dec_ready` is low in HOLD adds 1.
- Timeout: ERR is entered on the edge ending the ACK_TIMEOUT-th consecutive REQ cycle without ack.
- `ir_valid` first rises 2 cycles after reset release when `halt`=0 and memory acks immediately.

## Test plan
- Basic fetch: release reset with `pc`=0x00005, `halt`=0, `mem_ack` returned in the first REQ cycle with `mem_rdata`=0x2ABCD, `dec_ready`=1.
  - `mem_addr`=0x00005 in REQ.
  - `ir`=0x2ABCD and `ir_pc`=0x00005 with `ir_valid`=1 in the next cycle.
  - `pc_enable` is a single-cycle pulse in that same cycle.
- Decoder backpressure: hold `dec_ready`=0 for 4 cycles in HOLD.
  - `ir_valid` stays 1 and `ir` is stable.
  - `pc_enable` stays 0 until `dec_ready` rises, then pulses exactly once.
- Branch redirect: at handoff, the model PC jumps to 0x7FFFF.
  - The next `mem_addr` is 0x7FFFF, not the old PC+1.
  - A further sequential step wraps the PC to 0x00000.
- Memory wait and timeout with `ACK_TIMEOUT`=4:
  - Ack on the 4th REQ cycle: data is captured and the FSM goes to HOLD.
  - No ack: `fetch_err`=1 after 4 REQ cycles, `mem_req`=0, and the block stays in ERR until `rst`.
- Halt: assert `halt` while in HOLD.
  - The current instruction still hands off.
  - The FSM then stays in IDLE with `mem_req`=0 until `halt` drops.
  - A stray `mem_ack` in IDLE does not change `ir`.
- Reset mid-REQ: pulse `rst` while `mem_req`=1.
  - All outputs go to 0 asynchronously.
  - A fetch restarts from the current `pc` after reset release.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: samples the PC, performs a req/ack instruction memory read, holds the
// word for the decoder and pulses pc_enable on handoff; a silent memory latches fetch_err.
module instr_fetch #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 19,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              halt,
  output logic              pc_enable,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              dec_ready,
  output logic              fetch_err
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;
  localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  // an ack in the timeout cycle still wins over the error transition
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    ir_pc_d    = ir_pc_q;
    ir_d       = ir_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: if (!halt) begin
        state_d    = REQ;
        mem_addr_d = pc;
        wait_cnt_d = '0;
      end
      REQ: if (mem_ack) begin
        state_d = HOLD;
        ir_d    = mem_rdata;
        ir_pc_d = mem_addr_q;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        state_d    = (wait_cnt_q == LAST_WAIT) ? ERR : REQ;
      end
      HOLD: state_d = dec_ready ? IDLE : HOLD;
      default: state_d = ERR;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      ir_pc_q    <= '0;
      ir_q       <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      ir_pc_q    <= ir_pc_d;
      ir_q       <= ir_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
  assign mem_req   = state_q == REQ;
  assign ir_valid  = state_q == HOLD;
  assign fetch_err = state_q == ERR;
  assign pc_enable = (state_q == HOLD) && dec_ready;
  assign mem_addr  = mem_addr_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks plus a randomized run scored against a PC/memory model.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] pc;
  logic        halt;
  logic        pc_enable;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_ack;
  logic [18:0] mem_rdata;
  logic        ir_valid;
  logic [18:0] ir;
  logic [18:0] ir_pc;
  logic        dec_ready;
  logic        fetch_err;

  int          n_chk = 0;
  int          n_fail = 0;
  int          handoffs = 0;
  logic        mon_en = 1'b0;
  logic        adv;
  logic        prev_stall = 1'b0;
  logic [18:0] prev_ir = '0;
  logic [18:0] exp_q[$];
  int          wcnt = 0;
  int          dly = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(19), .DATA_W(19), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .halt(halt), .pc_enable(pc_enable),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .dec_ready(dec_ready), .fetch_err(fetch_err)
  );

  function automatic logic [18:0] memf(input logic [18:0] a);
    return a * 19'h2F1 ^ 19'h1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_mem_req"}, 32'(mem_req), 0);
    chk({nm, "_ir_valid"}, 32'(ir_valid), 0);
    chk({nm, "_pc_enable"}, 32'(pc_enable), 0);
    chk({nm, "_fetch_err"}, 32'(fetch_err), 0);
    chk({nm, "_mem_addr"}, 32'(mem_addr), 0);
    chk({nm, "_ir"}, 32'(ir), 0);
    chk({nm, "_ir_pc"}, 32'(ir_pc), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [31:0] ea;
      chk("sb_pc_enable", 32'(pc_enable), 32'(ir_valid && dec_ready));
      chk("sb_fetch_err", 32'(fetch_err), 0);
      if (mem_req) chk("sb_mem_addr", 32'(mem_addr), exp_q.size() != 0 ? 32'(exp_q[0]) : 32'hFFFF_FFFF);
      if (ir_valid && dec_ready) begin
        if (exp_q.size() != 0) ea = 32'(exp_q.pop_front());
        else ea = 32'hFFFF_FFFF;
        chk("sb_ir_pc", 32'(ir_pc), ea);
        chk("sb_ir", 32'(ir), 32'(memf(ea[18:0])));
      end
      if (ir_valid && prev_stall) chk("sb_ir_stable", 32'(ir), 32'(prev_ir));
      prev_stall = ir_valid && !dec_ready;
      prev_ir = ir;
    end
  end

  initial begin
    rst = 1'b1; pc = 19'h00005; halt = 1'b0; mem_ack = 1'b0; mem_rdata = '0; dec_ready = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    // basic fetch
    tick(); rst = 1'b0;
    @(negedge clk); chk("idle_mem_req", 32'(mem_req), 0);
    tick(); mem_ack = 1'b1; mem_rdata = 19'h2ABCD;
    @(negedge clk);
    chk("basic_mem_req", 32'(mem_req), 1);
    chk("basic_mem_addr", 32'(mem_addr), 32'h5);
    chk("basic_ir_valid_early", 32'(ir_valid), 0);
    tick(); mem_ack = 1'b0;
    @(negedge clk);
    chk("basic_ir_valid", 32'(ir_valid), 1);
    chk("basic_ir", 32'(ir), 32'h2ABCD);
    chk("basic_ir_pc", 32'(ir_pc), 32'h5);
    chk("basic_pc_enable", 32'(pc_enable), 1);
    tick(); pc = 19'h00006; dec_ready = 1'b0;
    @(negedge clk);
    chk("basic_pulse_end", 32'(pc_enable), 0);
    chk("basic_idle_valid", 32'(ir_valid), 0);
    // decoder backpressure
    tick(); mem_ack = 1'b1; mem_rdata = 19'h12345;
    @(negedge clk); chk("bp_mem_addr", 32'(mem_addr), 32'h6);
    tick(); mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ir_valid", 32'(ir_valid), 1);
      chk("bp_ir", 32'(ir), 32'h12345);
      chk("bp_pc_enable", 32'(pc_enable), 0);
      tick();
    end
    dec_ready = 1'b1;
    @(negedge clk); chk("bp_pc_enable_rise", 32'(pc_enable), 1);
    // branch redirect then wrap
    tick(); pc = 19'h7FFFF;
    @(negedge clk); chk("br_pulse_end", 32'(pc_enable), 0);
    tick(); mem_ack = 1'b1; mem_rdata = 19'h00111;
    @(negedge clk); chk("br_mem_addr", 32'(mem_addr), 32'h7FFFF);
    tick(); mem_ack = 1'b0;
    @(negedge clk);
    chk("br_ir_pc", 32'(ir_pc), 32'h7FFFF);
    chk("br_pc_enable", 32'(pc_enable), 1);
    tick(); pc = pc + 19'd1;
    tick(); mem_ack = 1'b1; mem_rdata = 19'h3C3C3;
    @(negedge clk); chk("wrap_mem_addr", 32'(mem_addr), 0);
    // halt asserted while holding: handoff still happens
    tick(); mem_ack = 1'b0; halt = 1'b1;
    @(negedge clk);
    chk("halt_ir_valid", 32'(ir_valid), 1);
    chk("halt_pc_enable", 32'(pc_enable), 1);
    tick(); pc = 19'h00001; mem_ack = 1'b1; mem_rdata = 19'h55555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_mem_req", 32'(mem_req), 0);
      chk("halt_stray_ack_ir", 32'(ir), 32'h3C3C3);
      tick();
    end
    halt = 1'b0; mem_ack = 1'b0;
    @(negedge clk); chk("halt_release_idle", 32'(mem_req), 0);
    // ack on the last allowed wait cycle
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 19'h0ABCD; end
      @(negedge clk);
      chk("wait_mem_req", 32'(mem_req), 1);
      chk("wait_mem_addr", 32'(mem_addr), 32'h1);
    end
    tick(); mem_ack = 1'b0;
    @(negedge clk);
    chk("wait_ir_valid", 32'(ir_valid), 1);
    chk("wait_fetch_err", 32'(fetch_err), 0);
    chk("wait_ir", 32'(ir), 32'h0ABCD);
    tick(); pc = 19'h00002;
    tick();
    @(negedge clk); chk("rstreq_mem_req", 32'(mem_req), 1);
    // asynchronous reset in the middle of a request
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    tick(); rst = 1'b0;
    tick();
    // no ack at all: timeout after four REQ cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_mem_req", 32'(mem_req), 1);
      chk("to_mem_addr", 32'(mem_addr), 32'h2);
      chk("to_fetch_err_early", 32'(fetch_err), 0);
      tick();
    end
    @(negedge clk);
    chk("to_fetch_err", 32'(fetch_err), 1);
    chk("to_mem_req_drop", 32'(mem_req), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      mem_ack = 1'($urandom); mem_rdata = 19'($urandom); dec_ready = 1'($urandom); halt = 1'($urandom);
      @(negedge clk);
      chk("err_sticky", 32'(fetch_err), 1);
      chk("err_mem_req", 32'(mem_req), 0);
      chk("err_ir_valid", 32'(ir_valid), 0);
      chk("err_pc_enable", 32'(pc_enable), 0);
    end
    tick(); rst = 1'b1; halt = 1'b0; mem_ack = 1'b0;
    @(negedge clk); chk("err_cleared", 32'(fetch_err), 0);
    // randomized run against the PC/memory model
    pc = 19'($urandom);
    exp_q.push_back(pc);
    mon_en = 1'b1;
    tick(); rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      adv = pc_enable;
      tick();
      rst = (c % 701 == 350);
      if (adv) begin
        pc = ($urandom_range(0, 3) == 0) ? 19'($urandom) : pc + 19'd1;
        exp_q.push_back(pc);
        handoffs++;
      end
      halt = ($urandom_range(0, 4) == 0);
      dec_ready = ($urandom_range(0, 2) != 0);
      if (mem_req) begin
        mem_ack = (wcnt == dly);
        mem_rdata = memf(mem_addr);
        wcnt++;
      end else begin
        wcnt = 0;
        dly = $urandom_range(0, 3);
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = 19'($urandom);
      end
    end
    @(negedge clk);
    mon_en = 1'b0;
    chk("rand_progress", 32'(handoffs >= 200), 1);
    chk("rand_queue_len", 32'(exp_q.size()), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
